io_led_seg_ctrl: RTL and testbench

Memory-mapped I/O peripheral sitting directly downstream of the CPU's memory/IO mux. It consumes the mux's LED-write strobe, switch-read strobe, address and 16-bit write data. It drives 16 LEDs and an 8-digit multiplexed seven-segment display. It returns debounced switch state as the 16-bit IO read data.

---
 rtl/io_map_pkg.sv | 34 +++
 rtl/io_led_seg_ctrl_if.sv | 12 +
 rtl/sw_debounce.sv | 40 ++++
 rtl/io_led_seg_ctrl.sv | 92 +++++++++
 tb/tb_io_led_seg_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/io_map_pkg.sv
// Address map and seven-segment glyph table shared by the LED/switch/display peripheral.
// Segment codes are active-low {dp,g,f,e,d,c,b,a} with dp always off.
package io_map_pkg;

  localparam logic [31:0] LED_ADDR       = 32'hFFFF_FC60;
  localparam logic [31:0] SW_ADDR        = 32'hFFFF_FC70;
  localparam logic [31:0] SEG_LO_ADDR    = 32'hFFFF_FC80;
  localparam logic [31:0] SEG_HI_ADDR    = 32'hFFFF_FC84;
  localparam logic [31:0] SEG_BLANK_ADDR = 32'hFFFF_FC88;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/io_led_seg_ctrl_if.sv
// CPU-side IO bus between the memory/IO mux and the LED/segment peripheral.
// The mux side is master; the peripheral returns combinational read data.
interface io_led_seg_ctrl_if;
  logic        led_ctrl;
  logic        switch_ctrl;
  logic [31:0] addr;
  logic [15:0] wdata;
  logic [15:0] io_rdata;

  modport master (output led_ctrl, switch_ctrl, addr, wdata, input io_rdata);
  modport slave  (input led_ctrl, switch_ctrl, addr, wdata, output io_rdata);
endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus shared-counter debounce for the 16 board switches.
// A step reaches sw_db 2 + DEBOUNCE_CYC cycles after it appears on sw_raw.
module sw_debounce #(
  parameter int DEBOUNCE_CYC = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw_raw,
  output logic [15:0] sw_db
);
  localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic [15:0]   sw_meta;
  logic [15:0]   sw_sync;
  logic [CW-1:0] deb_cnt;
  logic          changed;

  // Comparing against the first stage flags an edge of sw_sync as it happens,
  // so a saturated counter never accepts the very value that just arrived.
  assign changed = (sw_meta != sw_sync);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
      deb_cnt <= '0;
      sw_db   <= '0;
    end else begin
      sw_meta <= sw_raw;
      sw_sync <= sw_meta;
      if (changed)
        deb_cnt <= '0;
      else if (deb_cnt != CNT_MAX)
        deb_cnt <= deb_cnt + 1'b1;
      if (!changed && deb_cnt == CNT_MAX)
        sw_db <= sw_sync;
    end
  end
endmodule

// File: rtl/io_led_seg_ctrl.sv
// Memory-mapped LED, switch and 8-digit seven-segment peripheral.
// Writes land on the strobe edge; reads are combinational from current state.
module io_led_seg_ctrl
  import io_map_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CYC = 200000
) (
  input  logic               clk,
  input  logic               rst,
  io_led_seg_ctrl_if.slave   bus,
  input  logic [15:0]        sw_raw,
  output logic [15:0]        led,
  output logic [7:0]         seg_an,
  output logic [7:0]         seg_out
);
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  logic [15:0]   seg_lo;
  logic [15:0]   seg_hi;
  logic [7:0]    blank;
  logic [15:0]   sw_db;
  logic [SW-1:0] scan_cnt;
  logic [2:0]    dig;
  logic [31:0]   seg_all;
  logic [3:0]    nib;
  logic [15:0]   rdata;

  sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sw_debounce (
    .clk    (clk),
    .rst    (rst),
    .sw_raw (sw_raw),
    .sw_db  (sw_db)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led    <= '0;
      seg_lo <= '0;
      seg_hi <= '0;
      blank  <= 8'hFF;
    end else if (bus.led_ctrl) begin
      case (bus.addr)
        LED_ADDR:       led    <= bus.wdata;
        SEG_LO_ADDR:    seg_lo <= bus.wdata;
        SEG_HI_ADDR:    seg_hi <= bus.wdata;
        SEG_BLANK_ADDR: blank  <= bus.wdata[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.switch_ctrl) begin
      case (bus.addr)
        LED_ADDR:       rdata = led;
        SW_ADDR:        rdata = sw_db;
        SEG_LO_ADDR:    rdata = seg_lo;
        SEG_HI_ADDR:    rdata = seg_hi;
        SEG_BLANK_ADDR: rdata = {8'h00, blank};
        default:        rdata = '0;
      endcase
    end
  end
  assign bus.io_rdata = rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      dig      <= '0;
    end else if (scan_cnt == SCAN_MAX) begin
      scan_cnt <= '0;
      dig      <= dig + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign seg_all = {seg_hi, seg_lo};
  assign nib     = seg_all[{dig, 2'b00} +: 4];

  always_comb begin
    seg_an  = 8'hFF;
    seg_out = 8'hFF;
    if (!blank[dig]) begin
      seg_an[dig] = 1'b0;
      seg_out     = hex_to_seg(nib);
    end
  end
endmodule

// File: tb/tb_io_led_seg_ctrl.sv
// Scoreboard bench for io_led_seg_ctrl with SCAN_DIV=4, DEBOUNCE_CYC=8.
module tb_io_led_seg_ctrl;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam logic [31:0] A_LED   = 32'hFFFF_FC60;
  localparam logic [31:0] A_LED4  = 32'hFFFF_FC64;
  localparam logic [31:0] A_SW    = 32'hFFFF_FC70;
  localparam logic [31:0] A_LO    = 32'hFFFF_FC80;
  localparam logic [31:0] A_HI    = 32'hFFFF_FC84;
  localparam logic [31:0] A_BLANK = 32'hFFFF_FC88;
  localparam logic [31:0] A_UNMAP = 32'hFFFF_FC90;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] sw_raw = 16'h0000;
  logic [15:0] led;
  logic [7:0]  seg_an;
  logic [7:0]  seg_out;

  int vectors = 0;
  int miscompares = 0;
  int n_edges;

  logic [15:0] exp_q[$];
  logic [15:0] disp_q[$];
  logic [15:0] e;
  logic [15:0] m_lo, m_hi;
  logic [7:0]  m_blank;
  logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  io_led_seg_ctrl_if bus();

  io_led_seg_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYC(DEB)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .sw_raw  (sw_raw),
    .led     (led),
    .seg_an  (seg_an),
    .seg_out (seg_out)
  );

  always #5 clk = ~clk;

  // Edges seen since reset was released; the scan phase follows from it.
  always @(posedge clk or posedge rst) begin
    if (rst) n_edges <= 0;
    else     n_edges <= n_edges + 1;
  end

  function automatic logic [15:0] exp_disp(input int n);
    int d;
    logic [3:0] nb;
    d  = (n / SCAN_DIV) % 8;
    nb = (d < 4) ? m_lo[d*4 +: 4] : m_hi[(d-4)*4 +: 4];
    if (m_blank[d]) return 16'hFFFF;
    return {~(8'b1 << d), seg_tab[nb]};
  endfunction

  task bus_idle;
    bus.led_ctrl    = 1'b0;
    bus.switch_ctrl = 1'b0;
    bus.addr        = 32'h0;
    bus.wdata       = 16'h0;
  endtask

  task do_write(input logic [31:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.led_ctrl = 1'b1;
    bus.addr     = a;
    bus.wdata    = d;
    @(negedge clk);
    bus_idle();
  endtask

  task run_scan(input string name, input int cycles);
    int base;
    base = n_edges;
    for (int i = 0; i < cycles; i++) disp_q.push_back(exp_disp(base + i + 1));
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      e = disp_q.pop_front();
      vectors++;
      if ({seg_an, seg_out} !== e) begin
        miscompares++;
        $display("FAIL %s cyc %0d: an/seg got %h want %h", name, i, {seg_an, seg_out}, e);
      end
    end
  endtask

  task test_reset;
    bus_idle();
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (led !== 16'h0000) begin miscompares++; $display("FAIL reset_led: got %h want 0000", led); end
    vectors++;
    if ({seg_an, seg_out} !== 16'hFFFF) begin miscompares++; $display("FAIL reset_seg: got %h want FFFF", {seg_an, seg_out}); end
    bus.switch_ctrl = 1'b1; bus.addr = A_BLANK;
    #1;
    vectors++;
    if (bus.io_rdata !== 16'h00FF) begin miscompares++; $display("FAIL reset_blank_rd: got %h want 00FF", bus.io_rdata); end
    bus_idle();
    @(negedge clk);
    #2 rst = 1'b0;
    m_lo = 16'h0; m_hi = 16'h0; m_blank = 8'hFF;
  endtask

  task test_led;
    @(negedge clk);
    bus.led_ctrl = 1'b1; bus.switch_ctrl = 1'b1; bus.addr = A_LED; bus.wdata = 16'hA5C3;
    exp_q.push_back(16'hA5C3);
    #1;
    vectors++;
    if (bus.io_rdata !== 16'h0000) begin miscompares++; $display("FAIL led_rd_during_wr: got %h want 0000", bus.io_rdata); end
    vectors++;
    if (led !== 16'h0000) begin miscompares++; $display("FAIL led_before_edge: got %h want 0000", led); end
    @(negedge clk);
    bus_idle();
    e = exp_q.pop_front();
    vectors++;
    if (led !== e) begin miscompares++; $display("FAIL led_write: got %h want %h", led, e); end
    bus.switch_ctrl = 1'b1; bus.addr = A_LED;
    #1;
    vectors++;
    if (bus.io_rdata !== e) begin miscompares++; $display("FAIL led_readback: got %h want %h", bus.io_rdata, e); end
    do_write(A_LED4, 16'h1234);
    vectors++;
    if (led !== 16'hA5C3) begin miscompares++; $display("FAIL led_unmapped_wr: got %h want A5C3", led); end
    do_write(A_SW, 16'hFFFF);
    bus.switch_ctrl = 1'b1; bus.addr = A_SW;
    #1;
    vectors++;
    if (bus.io_rdata !== 16'h0000 || led !== 16'hA5C3) begin
      miscompares++; $display("FAIL sw_wr_ignored: got sw %h led %h want 0000 A5C3", bus.io_rdata, led);
    end
    bus_idle();
  endtask

  task test_scan;
    do_write(A_LO, 16'h3210);    m_lo = 16'h3210;
    do_write(A_HI, 16'h7654);    m_hi = 16'h7654;
    do_write(A_BLANK, 16'h0000); m_blank = 8'h00;
    run_scan("scan", 40);
  endtask

  task test_blank;
    do_write(A_BLANK, 16'h0002); m_blank = 8'h02;
    run_scan("blank", 36);
  endtask

  task test_read_gating;
    logic [31:0] addrs [3];
    addrs = '{A_LED, A_SW, A_BLANK};
    for (int i = 0; i < 3; i++) begin
      bus.switch_ctrl = 1'b0; bus.addr = addrs[i];
      #1;
      vectors++;
      if (bus.io_rdata !== 16'h0000) begin miscompares++; $display("FAIL rd_gated %h: got %h want 0000", addrs[i], bus.io_rdata); end
    end
    bus.switch_ctrl = 1'b1; bus.addr = A_UNMAP;
    #1;
    vectors++;
    if (bus.io_rdata !== 16'h0000) begin miscompares++; $display("FAIL rd_unmapped: got %h want 0000", bus.io_rdata); end
    bus.addr = A_HI;
    #1;
    vectors++;
    if (bus.io_rdata !== 16'h7654) begin miscompares++; $display("FAIL rd_seg_hi: got %h want 7654", bus.io_rdata); end
    bus.addr = A_BLANK;
    #1;
    vectors++;
    if (bus.io_rdata !== 16'h0002) begin miscompares++; $display("FAIL rd_blank: got %h want 0002", bus.io_rdata); end
    bus_idle();
  endtask

  task test_debounce;
    logic [15:0] vals [3];
    int len;
    vals = '{16'h0000, 16'h00FF, 16'h0000};
    @(negedge clk);
    bus.switch_ctrl = 1'b1; bus.addr = A_SW;
    sw_raw = 16'h00FF;
    for (int k = 1; k <= 12; k++) exp_q.push_back((k >= DEB + 2) ? 16'h00FF : 16'h0000);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (bus.io_rdata !== e) begin miscompares++; $display("FAIL deb_step k=%0d: got %h want %h", k, bus.io_rdata, e); end
    end
    for (int s = 0; s < 3; s++) begin
      sw_raw = vals[s];
      len = (s == 2) ? 12 : 5;
      for (int k = 1; k <= len; k++)
        exp_q.push_back((s == 2 && k >= DEB + 2) ? 16'h0000 : 16'h00FF);
      for (int k = 1; k <= len; k++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (bus.io_rdata !== e) begin miscompares++; $display("FAIL deb_bounce s=%0d k=%0d: got %h want %h", s, k, bus.io_rdata, e); end
      end
    end
    bus_idle();
  endtask

  task test_async_reset;
    @(negedge clk);
    sw_raw = 16'h00FF;
    repeat (12) @(negedge clk);
    bus.switch_ctrl = 1'b1; bus.addr = A_SW;
    #1;
    vectors++;
    if (bus.io_rdata !== 16'h00FF) begin miscompares++; $display("FAIL pre_rst_sw: got %h want 00FF", bus.io_rdata); end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (bus.io_rdata !== 16'h0000) begin miscompares++; $display("FAIL arst_sw: got %h want 0000", bus.io_rdata); end
    vectors++;
    if (led !== 16'h0000 || {seg_an, seg_out} !== 16'hFFFF) begin
      miscompares++; $display("FAIL arst_outputs: led %h an/seg %h want 0000 FFFF", led, {seg_an, seg_out});
    end
    bus.addr = A_BLANK;
    #1;
    vectors++;
    if (bus.io_rdata !== 16'h00FF) begin miscompares++; $display("FAIL arst_blank_rd: got %h want 00FF", bus.io_rdata); end
    bus_idle();
    @(negedge clk);
    #2 rst = 1'b0;
    m_lo = 16'h0; m_hi = 16'h0; m_blank = 8'hFF;
    do_write(A_BLANK, 16'h0000); m_blank = 8'h00;
    run_scan("post_rst_scan", 12);
  endtask

  initial begin
    test_reset();
    test_led();
    test_scan();
    test_blank();
    test_read_gating();
    test_debounce();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
